// File: rtl/axi_burst_master_pkg.sv
// ============================================================================
//  axi_burst_master_pkg
//  Shared AXI encodings and FSM state types for axi_burst_master.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package axi_burst_master_pkg;

    localparam logic [1:0] AXBURST_INCR  = 2'b01;

    localparam logic [1:0] AXRESP_OKAY   = 2'b00;
    localparam logic [1:0] AXRESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXRESP_SLVERR = 2'b10;
    localparam logic [1:0] AXRESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_burst_master_wdata_fifo.sv
// ============================================================================
//  axi_wdata_fifo
//  Write-data FIFO; accepts a push while full only when a pop frees a slot.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module axi_wdata_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/axi_burst_master.sv
// ============================================================================
//  axi_burst_master
//  Round-robin multi-port AXI read master plus FIFO-buffered write master.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int NUM_RD      = 2,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int WFIFO_DEPTH = 8,
    parameter int LINE_OFF_W  = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_RD-1:0]     rd_req,
    input  logic [NUM_RD*32-1:0]  rd_addr,
    input  logic [NUM_RD*8-1:0]   rd_len,
    output logic [NUM_RD-1:0]     rd_grant,
    output logic [NUM_RD-1:0]     rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  rd_err,
    input  logic                  wr_req,
    input  logic [31:0]           wr_addr,
    input  logic [7:0]            wr_len,
    output logic                  wr_ack,
    input  logic                  wr_push,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  wr_full,
    output logic                  wr_done,
    output logic                  wr_err,
    output logic [ID_W-1:0]       arid,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ID_W-1:0]       awid,
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int         STRB_W = DATA_W / 8;
    localparam int         RR_W   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int         FIFO_W = DATA_W + STRB_W;
    localparam int         CNT_W  = $clog2(WFIFO_DEPTH) + 1;
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

    rd_state_t          r_rd_state;
    wr_state_t          r_wr_state;
    logic [RR_W-1:0]    r_rr_ptr;
    logic [RR_W-1:0]    r_win;
    logic [NUM_RD-1:0]  r_rd_grant;
    logic [ID_W-1:0]    r_arid;
    logic [31:0]        r_araddr;
    logic [7:0]         r_arlen;
    logic               r_arvalid;
    logic               r_rready;
    logic [31:0]        r_awaddr;
    logic [7:0]         r_awlen;
    logic               r_awvalid;
    logic               r_wr_ack;
    logic [7:0]         r_beat_cnt;
    logic               r_wbeats_done;
    logic               r_bready;
    logic               r_wr_done;
    logic               r_wr_err;

    logic [NUM_RD-1:0]  w_mask;
    logic [NUM_RD-1:0]  w_elig;
    logic               w_any;
    logic [RR_W-1:0]    w_win;
    logic [31:0]        w_sel_addr;
    logic [7:0]         w_sel_len;
    logic               w_rhs;
    logic               w_wvalid;
    logic               w_whs;
    logic               w_wlast;
    logic [FIFO_W-1:0]  w_fifo_dout;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_unused;

    // A read hitting the cache line currently being written back waits for the write.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_mask
        logic [31:0] w_port_addr;
        assign w_port_addr = rd_addr[i*32 +: 32];
        assign w_mask[i]   = (r_wr_state != W_IDLE) &&
                             (w_port_addr[31:LINE_OFF_W] == r_awaddr[31:LINE_OFF_W]);
    end

    assign w_elig = rd_req & ~w_mask;

    always_comb begin
        w_any      = 1'b0;
        w_win      = '0;
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!w_any && w_elig[i] && (RR_W'(i) >= r_rr_ptr)) begin
                w_any      = 1'b1;
                w_win      = RR_W'(i);
                w_sel_addr = rd_addr[i*32 +: 32];
                w_sel_len  = rd_len[i*8 +: 8];
            end
        end
        for (int i = 0; i < NUM_RD; i++) begin
            if (!w_any && w_elig[i]) begin
                w_any      = 1'b1;
                w_win      = RR_W'(i);
                w_sel_addr = rd_addr[i*32 +: 32];
                w_sel_len  = rd_len[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_state <= R_IDLE;
            r_rr_ptr   <= '0;
            r_win      <= '0;
            r_rd_grant <= '0;
            r_arid     <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            r_rd_grant <= '0;
            case (r_rd_state)
                R_IDLE: begin
                    if (w_any) begin
                        r_win      <= w_win;
                        r_arid     <= ID_W'(w_win);
                        r_araddr   <= w_sel_addr;
                        r_arlen    <= w_sel_len;
                        r_arvalid  <= 1'b1;
                        r_rd_grant <= NUM_RD'(1) << w_win;
                        r_rd_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        r_rready   <= 1'b0;
                        r_rr_ptr   <= (r_win == RR_W'(NUM_RD - 1)) ? '0 : r_win + RR_W'(1);
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign w_rhs    = rvalid & r_rready;
    assign rd_valid = w_rhs ? (NUM_RD'(1) << r_win) : '0;
    assign rd_data  = rdata;
    assign rd_last  = w_rhs & rlast;
    assign rd_err   = w_rhs & (rresp != AXRESP_OKAY);

    // W beats may go out while AW is still pending, so a short burst can finish first.
    assign w_wvalid = ~w_fifo_empty &
                      (((r_wr_state == W_AW) & ~r_wbeats_done) | (r_wr_state == W_DATA));
    assign w_whs    = w_wvalid & wready;
    assign w_wlast  = w_wvalid & (r_beat_cnt == 8'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_state    <= W_IDLE;
            r_awaddr      <= '0;
            r_awlen       <= '0;
            r_awvalid     <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_beat_cnt    <= '0;
            r_wbeats_done <= 1'b0;
            r_bready      <= 1'b0;
            r_wr_done     <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_wr_ack  <= 1'b0;
            r_wr_done <= 1'b0;
            r_wr_err  <= 1'b0;
            case (r_wr_state)
                W_IDLE: begin
                    if (wr_req) begin
                        r_awaddr      <= wr_addr;
                        r_awlen       <= wr_len;
                        r_awvalid     <= 1'b1;
                        r_wr_ack      <= 1'b1;
                        r_beat_cnt    <= wr_len;
                        r_wbeats_done <= 1'b0;
                        r_wr_state    <= W_AW;
                    end
                end
                W_AW: begin
                    if (w_whs) begin
                        if (w_wlast) r_wbeats_done <= 1'b1;
                        else         r_beat_cnt    <= r_beat_cnt - 8'd1;
                    end
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        if (r_wbeats_done || (w_whs && w_wlast)) begin
                            r_bready   <= 1'b1;
                            r_wr_state <= W_RESP;
                        end else begin
                            r_wr_state <= W_DATA;
                        end
                    end
                end
                W_DATA: begin
                    if (w_whs) begin
                        if (w_wlast) begin
                            r_bready   <= 1'b1;
                            r_wr_state <= W_RESP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt - 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        r_bready   <= 1'b0;
                        r_wr_done  <= 1'b1;
                        r_wr_err   <= (bresp != AXRESP_OKAY);
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    axi_wdata_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (wr_push),
        .push_data ({wr_strb, wr_data}),
        .pop       (w_whs),
        .pop_data  (w_fifo_dout),
        .full      (wr_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign rd_grant = r_rd_grant;
    assign arid     = r_arid;
    assign araddr   = r_araddr;
    assign arlen    = r_arlen;
    assign arsize   = AXSIZE;
    assign arburst  = AXBURST_INCR;
    assign arvalid  = r_arvalid;
    assign rready   = r_rready;
    assign awid     = '0;
    assign awaddr   = r_awaddr;
    assign awlen    = r_awlen;
    assign awsize   = AXSIZE;
    assign awburst  = AXBURST_INCR;
    assign awvalid  = r_awvalid;
    assign wvalid   = w_wvalid;
    assign wlast    = w_wlast;
    assign wdata    = w_wvalid ? w_fifo_dout[DATA_W-1:0] : '0;
    assign wstrb    = w_wvalid ? w_fifo_dout[FIFO_W-1:DATA_W] : '0;
    assign bready   = r_bready;
    assign wr_ack   = r_wr_ack;
    assign wr_done  = r_wr_done;
    assign wr_err   = r_wr_err;

    assign w_unused = ^{rid, bid, w_fifo_count};

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_master.sv
// ============================================================================
//  tb_axi_burst_master
//  Directed self-checking bench for axi_burst_master (NUM_RD=2, DATA_W=32).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_burst_master;

    localparam int NUM_RD = 2;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NUM_RD-1:0]    rd_req;
    logic [NUM_RD*32-1:0] rd_addr;
    logic [NUM_RD*8-1:0]  rd_len;
    logic [NUM_RD-1:0]    rd_grant, rd_valid;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_last, rd_err;
    logic                 wr_req, wr_ack, wr_push, wr_full, wr_done, wr_err;
    logic [31:0]          wr_addr;
    logic [7:0]           wr_len;
    logic [DATA_W-1:0]    wr_data;
    logic [3:0]           wr_strb;
    logic [ID_W-1:0]      arid, rid, awid, bid;
    logic [31:0]          araddr, awaddr;
    logic [7:0]           arlen, awlen;
    logic [2:0]           arsize, awsize;
    logic [1:0]           arburst, awburst, rresp, bresp;
    logic                 arvalid, arready, rlast, rvalid, rready;
    logic                 awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DATA_W-1:0]    rdata, wdata;
    logic [3:0]           wstrb;

    int total = 0;
    int bad   = 0;
    int beat;
    logic [1:0] eg;

    always #5 clk = ~clk;

    axi_burst_master #(
        .NUM_RD(NUM_RD), .DATA_W(DATA_W), .ID_W(ID_W), .WFIFO_DEPTH(8), .LINE_OFF_W(5)
    ) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_grant(rd_grant),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
        .wr_push(wr_push), .wr_data(wr_data), .wr_strb(wr_strb), .wr_full(wr_full),
        .wr_done(wr_done), .wr_err(wr_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; rd_req = '0; rd_addr = '0; rd_len = '0;
        wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_push = 1'b0; wr_data = '0; wr_strb = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        tick; tick;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_rready",  rready, 0);
        chk("rst_bready",  bready, 0);
        chk("rst_grant",   rd_grant, 0);
        chk("rst_wvalid",  wvalid, 0);
        chk("rst_araddr",  araddr, 0);
        chk("rst_full",    wr_full, 0);
        resetn = 1'b1;
        tick;

        // Single read on port 0
        rd_addr[31:0] = 32'h1000_0040; rd_len[7:0] = 8'd7; rd_req = 2'b01;
        tick;
        chk("t1_grant", rd_grant, 2'b01);
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1000_0040);
        chk("t1_arlen", arlen, 7);
        chk("t1_arid", arid, 0);
        chk("t1_arsize", arsize, 2);
        chk("t1_arburst", arburst, 1);
        rd_req = 2'b00;
        tick;
        chk("t1_grant_pulse", rd_grant, 0);
        chk("t1_arvalid_hold", arvalid, 1);
        tick;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        chk("t1_arvalid_drop", arvalid, 0);
        chk("t1_rready", rready, 1);
        for (int i = 0; i < 8; i++) begin
            rvalid = 1'b1; rdata = 32'hD000_0000 + i; rlast = (i == 7);
            #1;
            chk("t1_rd_valid", rd_valid, 2'b01);
            chk("t1_rd_data", rd_data, 32'hD000_0000 + i);
            chk("t1_rd_last", rd_last, (i == 7));
            chk("t1_rd_err", rd_err, 0);
            tick;
        end
        rvalid = 1'b0; rlast = 1'b0;
        chk("t1_rready_drop", rready, 0);

        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        tick;

        // Contention: both ports always requesting
        rd_addr = {32'h3000_1000, 32'h3000_0000}; rd_len = '0; rd_req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            eg = (r % 2 == 0) ? 2'b01 : 2'b10;
            tick;
            chk("t2_grant", rd_grant, eg);
            chk("t2_arid", arid, r % 2);
            arready = 1'b1;
            tick;
            arready = 1'b0;
            rvalid = 1'b1; rlast = 1'b1; rdata = r; rresp = (r == 3) ? 2'b10 : 2'b00;
            #1;
            chk("t2_rd_valid", rd_valid, eg);
            chk("t2_rd_err", rd_err, (r == 3));
            tick;
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        rd_req = 2'b00;

        // Write burst pushed before AW, wready toggling
        for (int i = 0; i < 8; i++) begin
            wr_push = 1'b1; wr_data = 32'hA0 + i; wr_strb = 4'hF;
            tick;
        end
        wr_push = 1'b0;
        chk("t3_full_at_8", wr_full, 1);
        chk("t3_idle_no_wvalid", wvalid, 0);
        wr_addr = 32'h4000_0000; wr_len = 8'd7; wr_req = 1'b1;
        tick;
        wr_req = 1'b0;
        chk("t3_ack", wr_ack, 1);
        chk("t3_awvalid", awvalid, 1);
        chk("t3_awaddr", awaddr, 32'h4000_0000);
        chk("t3_awlen", awlen, 7);
        chk("t3_w_before_aw", wvalid, 1);
        awready = 1'b1;
        tick;
        awready = 1'b0;
        chk("t3_awvalid_drop", awvalid, 0);
        chk("t3_ack_pulse", wr_ack, 0);
        beat = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            wready = (c % 2 == 0);
            #1;
            if (wvalid && wready) begin
                chk("t3_wdata", wdata, 32'hA0 + beat);
                chk("t3_wlast", wlast, (beat == 7));
                chk("t3_wstrb", wstrb, 4'hF);
                beat++;
            end
            tick;
        end
        wready = 1'b0;
        chk("t3_beats", beat, 8);
        chk("t3_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b00;
        tick;
        bvalid = 1'b0;
        chk("t3_done", wr_done, 1);
        chk("t3_err", wr_err, 0);
        tick;
        chk("t3_done_pulse", wr_done, 0);

        // FIFO full with wready low, then hazard-blocked read
        for (int i = 0; i < 9; i++) begin
            wr_push = 1'b1; wr_data = 32'hB0 + i; wr_strb = 4'hF;
            tick;
            if (i == 6) chk("t4_not_full_7", wr_full, 0);
            if (i == 7) chk("t4_full_8", wr_full, 1);
        end
        wr_push = 1'b0;
        chk("t4_full_9", wr_full, 1);
        wr_addr = 32'h2000_0020; wr_len = 8'd7; wr_req = 1'b1;
        tick;
        wr_req = 1'b0;
        chk("t5_ack", wr_ack, 1);
        rd_addr[63:32] = 32'h2000_0034; rd_len[15:8] = 8'd0; rd_req = 2'b10;
        awready = 1'b1;
        tick;
        awready = 1'b0;
        chk("t5_masked_aw", arvalid, 0);
        tick;
        wready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t4_wdata", wdata, 32'hB0 + i);
            chk("t4_wlast", wlast, (i == 7));
            chk("t5_masked", arvalid, 0);
            tick;
        end
        wready = 1'b0;
        bvalid = 1'b1;
        tick;
        bvalid = 1'b0;
        chk("t5_done", wr_done, 1);
        chk("t5_still_masked", arvalid, 0);
        tick;
        chk("t5_arvalid", arvalid, 1);
        chk("t5_grant", rd_grant, 2'b10);
        chk("t5_araddr", araddr, 32'h2000_0034);
        chk("t5_arid", arid, 1);
        rd_req = 2'b00; arready = 1'b1;
        tick;
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
        tick;
        rvalid = 1'b0; rlast = 1'b0;

        // Different line is not blocked; FIFO must be empty (9th push dropped)
        wr_addr = 32'h2000_0020; wr_len = 8'd0; wr_req = 1'b1;
        tick;
        wr_req = 1'b0;
        chk("t6_ack", wr_ack, 1);
        chk("t4_fifo_drop", wvalid, 0);
        rd_addr[31:0] = 32'h2000_0040; rd_len[7:0] = 8'd0; rd_req = 2'b01; awready = 1'b1;
        tick;
        awready = 1'b0;
        chk("t6_arvalid", arvalid, 1);
        chk("t6_grant", rd_grant, 2'b01);
        chk("t6_araddr", araddr, 32'h2000_0040);
        rd_req = 2'b00; arready = 1'b1;
        tick;
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
        tick;
        rvalid = 1'b0; rlast = 1'b0;
        wr_push = 1'b1; wr_data = 32'hC0; wr_strb = 4'h3; wready = 1'b1;
        tick;
        wr_push = 1'b0;
        chk("t6_wvalid", wvalid, 1);
        chk("t6_wlast", wlast, 1);
        chk("t6_wdata", wdata, 32'hC0);
        chk("t6_wstrb", wstrb, 4'h3);
        tick;
        wready = 1'b0;
        chk("t6_bready", bready, 1);
        bvalid = 1'b1; bresp = 2'b10;
        tick;
        bvalid = 1'b0; bresp = 2'b00;
        chk("t6_done", wr_done, 1);
        chk("t6_err", wr_err, 1);

        // Reset during beat 3 of a read
        rd_addr[31:0] = 32'h5000_0000; rd_len[7:0] = 8'd7; rd_req = 2'b01;
        tick;
        chk("t7_grant", rd_grant, 2'b01);
        rd_req = 2'b00; arready = 1'b1;
        tick;
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rvalid = 1'b1; rlast = 1'b0; rdata = 32'hE0 + i;
            tick;
        end
        rdata = 32'hE2;
        #1;
        chk("t7_beat3", rd_valid, 2'b01);
        resetn = 1'b0;
        #1;
        chk("t7_rst_rd_valid", rd_valid, 0);
        chk("t7_rst_rready", rready, 0);
        chk("t7_rst_arvalid", arvalid, 0);
        chk("t7_rst_araddr", araddr, 0);
        chk("t7_rst_awvalid", awvalid, 0);
        chk("t7_rst_bready", bready, 0);
        rvalid = 1'b0;
        tick;
        resetn = 1'b1;
        tick;
        rd_addr[63:32] = 32'h5000_1000; rd_len[15:8] = 8'd1; rd_req = 2'b10;
        tick;
        chk("t7_new_grant", rd_grant, 2'b10);
        chk("t7_new_araddr", araddr, 32'h5000_1000);
        chk("t7_new_arlen", arlen, 1);
        rd_req = 2'b00; arready = 1'b1;
        tick;
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rvalid = 1'b1; rlast = (i == 1); rdata = 32'hF0 + i;
            #1;
            chk("t7_new_rd_valid", rd_valid, 2'b10);
            chk("t7_new_rd_last", rd_last, (i == 1));
            tick;
        end
        rvalid = 1'b0; rlast = 1'b0;
        chk("t7_new_rready_drop", rready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
